// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scanner.
package seg_pkg;

   typedef enum logic [0:0] {
      GUARD = 1'b0,
      ON    = 1'b1
   } phase_t;

   localparam logic AN_OFF = 1'b1;
   localparam logic DP_OFF = 1'b1;
   localparam int   NIB_W  = 4;

endpackage

// File: rtl/seg_prescale.sv
// Slot counter for the display scanner: counts 0..REFRESH_DIV-1 and strobes
// terminal count (last cycle of a slot) and guard-done (last blank cycle).
module seg_prescale #(
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 500,
   parameter int CW           = $clog2(REFRESH_DIV)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] cnt,
   output logic          tc,
   output logic          guard_done
);

   assign tc         = (cnt == CW'(REFRESH_DIV - 1));
   assign guard_done = (cnt == CW'(GUARD_CYCLES - 1));

   // slot counter, wraps at the end of every digit slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= {CW{1'b0}};
      end else if (tc) begin
         cnt <= {CW{1'b0}};
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner with per-frame snapshot of the value.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan
   import seg_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [NIB_W-1:0]      nibble,
   output logic [DIGITS-1:0]     an,
   output logic                  dp,
   output logic                  frame_tick
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]       cnt_s;
   logic                tc_s;
   logic                guard_done_s;
   logic [IW-1:0]       idx_r;
   phase_t              phase_r;
   phase_t              phase_next_s;
   logic [4*DIGITS-1:0] shadow_val_r;
   logic [DIGITS-1:0]   shadow_dp_r;
   logic                prime_r;
   logic                idx_last_s;
   logic                snap_s;
   logic                frame_start_s;
   logic [4*DIGITS-1:0] frame_val_s;
   logic [NIB_W-1:0]    digit_s;
   logic [DIGITS-1:0]   an_on_s;
   logic                blank_s;

   seg_prescale #(
      .REFRESH_DIV  (REFRESH_DIV),
      .GUARD_CYCLES (GUARD_CYCLES),
      .CW           (CW)
   ) u_prescale (
      .clk        (clk),
      .rst        (rst),
      .cnt        (cnt_s),
      .tc         (tc_s),
      .guard_done (guard_done_s)
   );

   // snapshot/frame decode; the very first digit after reset bypasses the
   // shadow because it is being loaded on that same edge
   always_comb begin
      idx_last_s    = (idx_r == IW'(DIGITS - 1));
      snap_s        = prime_r | (tc_s & idx_last_s);
      frame_start_s = (cnt_s == {CW{1'b0}}) & (idx_r == {IW{1'b0}});
      frame_val_s   = prime_r ? value : shadow_val_r;
      digit_s       = frame_val_s[{idx_r, 2'b00} +: NIB_W];
      an_on_s       = ~(DIGITS'(1) << idx_r);
   end

`ifdef SEG_SCAN_LZ_BLANK_EN
   logic zero_run_s;

   // blank digit idx when it and every more significant shadow digit are zero
   always_comb begin
      blank_s    = 1'b0;
      zero_run_s = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run_s = zero_run_s & (shadow_val_r[4*i +: 4] == 4'h0);
         blank_s    = blank_s | ((idx_r == IW'(i)) & zero_run_s);
      end
   end
`else
   assign blank_s = 1'b0;
`endif

   // phase next-state: ON after the guard window, back to GUARD at slot end
   always_comb begin
      phase_next_s = phase_r;
      case (phase_r)
         GUARD: begin
            if (tc_s)              phase_next_s = GUARD;
            else if (guard_done_s) phase_next_s = ON;
            else                   phase_next_s = GUARD;
         end
         ON: begin
            if (tc_s) phase_next_s = GUARD;
            else      phase_next_s = ON;
         end
         default: phase_next_s = GUARD;
      endcase
   end

   // scan state, digit index and frame shadow registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_r      <= GUARD;
         idx_r        <= {IW{1'b0}};
         shadow_val_r <= {(4*DIGITS){1'b0}};
         shadow_dp_r  <= {DIGITS{1'b0}};
         prime_r      <= 1'b1;
      end else begin
         phase_r <= phase_next_s;
         if (tc_s) begin
            idx_r <= idx_last_s ? {IW{1'b0}} : idx_r + IW'(1);
         end
         if (snap_s) begin
            shadow_val_r <= value;
            shadow_dp_r  <= dp_in;
            prime_r      <= 1'b0;
         end
      end
   end

   // registered outputs; nibble only moves at slot start while anodes are off
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an         <= {DIGITS{AN_OFF}};
         nibble     <= {NIB_W{1'b0}};
         dp         <= DP_OFF;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_start_s;
         if (cnt_s == {CW{1'b0}}) begin
            nibble <= digit_s;
         end
         if ((phase_r == ON) && !blank_s) begin
            an <= an_on_s;
            dp <= ~shadow_dp_r[idx_r];
         end else begin
            an <= {DIGITS{AN_OFF}};
            dp <= DP_OFF;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan (DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2).
// Honours SEG_SCAN_LZ_BLANK_EN when the build defines it.
module tb_seg_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = 16'h1234;
   logic [3:0]  dp_in = 4'b0000;
   logic [3:0]  nibble;
   logic [3:0]  an;
   logic        dp;
   logic        frame_tick;

   int total = 0;
   int bad   = 0;
   int ecnt  = 0;

   seg_scan #(
      .DIGITS       (4),
      .REFRESH_DIV  (8),
      .GUARD_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .dp_in      (dp_in),
      .nibble     (nibble),
      .an         (an),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s edge=%0d got=%h expected=%h", tag, ecnt, got, exp);
      end
   endtask

   function automatic bit is_blank(input int d, input logic [15:0] v);
`ifdef SEG_SCAN_LZ_BLANK_EN
      return (d > 0) && ((v >> (4 * d)) == 16'h0000);
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      ecnt++;
      #2;
   endtask

   // edges first..last; frame contents switch to v_new from edge new_from on
   task automatic run(input int first, input int last, input logic [15:0] v_old,
                      input logic [15:0] v_new, input int new_from, input logic [3:0] dpv);
      for (int e = first; e <= last; e++) begin
         logic [15:0] v;
         int pos;
         int d;
         bit lit;
         tick();
         v   = (e >= new_from) ? v_new : v_old;
         pos = (e - 1) % 8;
         d   = ((e - 1) / 8) % 4;
         lit = (pos >= 2) && !is_blank(d, v);
         check("an", {12'h000, an}, lit ? {12'h000, ~(4'b0001 << d)} : 16'h000F);
         check("nibble", {12'h000, nibble}, (v >> (4 * d)) & 16'h000F);
         check("dp", {15'h0000, dp}, lit ? {15'h0000, ~dpv[d]} : 16'h0001);
         check("frame_tick", {15'h0000, frame_tick}, ((e - 1) % 32 == 0) ? 16'h0001 : 16'h0000);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_an", {12'h000, an}, 16'h000F);
      check("rst_nibble", {12'h000, nibble}, 16'h0000);
      check("rst_dp", {15'h0000, dp}, 16'h0001);
      check("rst_ft", {15'h0000, frame_tick}, 16'h0000);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      ecnt = 0;
   endtask

   initial begin
      #12;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      ecnt = 0;

      // basic scan, value change mid-frame is held off until the next frame
      run(1, 12, 16'h1234, 16'h1234, 1000, 4'b0000);
      value = 16'hABCD;
      run(13, 40, 16'h1234, 16'hABCD, 33, 4'b0000);

      // decimal point on digit 2 plus asynchronous reset before edge 13
      value = 16'h1234;
      dp_in = 4'b0100;
      apply_reset();
      run(1, 12, 16'h1234, 16'h1234, 1000, 4'b0100);
      #1 rst = 1'b1;
      #1 check_reset_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      ecnt = 0;
      run(1, 40, 16'h1234, 16'h1234, 1000, 4'b0100);

      // leading zeros: blanked only when the blanking feature is built in
      dp_in = 4'b0000;
      value = 16'h0050;
      apply_reset();
      run(1, 32, 16'h0050, 16'h0050, 1000, 4'b0000);
      value = 16'h0000;
      apply_reset();
      run(1, 32, 16'h0000, 16'h0000, 1000, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout edge=%0d", ecnt);
      $fatal(1, "bench time limit reached");
   end

endmodule
